// File: rtl/noc_packet_datapath_pkg.sv
// noc_pkg: shared state type, parameter defaults and header field layout for the NoC packet datapath.
package noc_pkg;
    typedef enum logic [1:0] {HDR = 2'd0, BODY = 2'd1, DONE = 2'd2} dp_state_t;
    localparam int FLIT_W_DEF = 32;
    localparam int LEN_W_DEF  = 4;
    localparam int DEPTH_DEF  = 8;
    localparam int CNT_W_DEF  = 16;
    localparam int LEN_LSB    = 0;
endpackage

// File: rtl/noc_packet_datapath_if.sv
// noc_packet_datapath_if: controller, source and destination link signals of the packet datapath.
interface noc_packet_datapath_if import noc_pkg::*; #(
    parameter int FLIT_W = FLIT_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) ();
    logic [FLIT_W-1:0] src_flit;
    logic              get_packet;
    logic              transfer_en;
    logic              stop;
    logic              src_hold;
    logic [FLIT_W-1:0] dest_flit;
    logic              dest_valid;
    logic              dest_accept;
    logic [CNT_W-1:0]  pkt_count;
    modport master (
        output src_flit, get_packet, transfer_en, dest_accept,
        input  stop, src_hold, dest_flit, dest_valid, pkt_count
    );
    modport slave (
        input  src_flit, get_packet, transfer_en, dest_accept,
        output stop, src_hold, dest_flit, dest_valid, pkt_count
    );
endinterface

// File: rtl/noc_packet_datapath_fifo.sv
// noc_flit_fifo: flit buffer with first-word-fall-through head; output reads 0 while empty.
module noc_flit_fifo import noc_pkg::*; #(
    parameter int FLIT_W = FLIT_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [FLIT_W-1:0] din,
    output logic [FLIT_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = $clog2(DEPTH);
    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [PTR_W:0]    count;
    logic              do_push, do_pop;
    assign full    = count == (PTR_W+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
    // pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(do_pop);
            wr_ptr <= wr_ptr + PTR_W'(do_push);
            count  <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end
endmodule

// File: rtl/noc_packet_datapath.sv
// noc_packet_datapath: captures controller-gated flits, tracks packet length and drains to the destination link.
// Optional completed-packet counter enabled by defining NOC_DP_PKT_CNT_EN.
module noc_packet_datapath import noc_pkg::*; #(
    parameter int FLIT_W = FLIT_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input logic                  clk,
    input logic                  reset,
    noc_packet_datapath_if.slave bus
);
    localparam logic [1:0] ST_HDR  = HDR;
    localparam logic [1:0] ST_BODY = BODY;
    localparam logic [1:0] ST_DONE = DONE;
    logic [1:0]       state;
    logic [LEN_W-1:0] remaining, len;
    logic             full, empty, cap;
    assign len            = bus.src_flit[LEN_LSB +: LEN_W];
    assign cap            = bus.get_packet & bus.transfer_en & ~full & (state != ST_DONE);
    assign bus.stop       = state == ST_DONE;
    assign bus.src_hold   = full;
    assign bus.dest_valid = ~empty;
    noc_flit_fifo #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cap),
        .pop   (bus.dest_accept & ~empty),
        .din   (bus.src_flit),
        .dout  (bus.dest_flit),
        .full  (full),
        .empty (empty)
    );
    // DONE lasts one cycle and ignores the controller, so stop is purely registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_HDR;
            remaining <= '0;
        end else if (state == ST_DONE) begin
            state <= ST_HDR;
        end else if (cap) begin
            if (state == ST_HDR) begin
                state     <= len == '0 ? ST_DONE : ST_BODY;
                remaining <= len;
            end else begin
                state     <= remaining == LEN_W'(1) ? ST_DONE : ST_BODY;
                remaining <= remaining - LEN_W'(1);
            end
        end
    end
`ifdef NOC_DP_PKT_CNT_EN
    logic [CNT_W-1:0] pkt_count;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pkt_count <= '0;
        else if (state == ST_DONE) pkt_count <= pkt_count + CNT_W'(1);
    end
    assign bus.pkt_count = pkt_count;
`else
    assign bus.pkt_count = CNT_W'(0);
`endif
endmodule

// File: tb/tb_noc_packet_datapath.sv
// tb_noc_packet_datapath: directed stimulus with a flit scoreboard checked by an independent destination monitor.
module tb_noc_packet_datapath;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    noc_packet_datapath_if #(.FLIT_W(32), .CNT_W(16)) bus ();
    noc_packet_datapath #(.FLIT_W(32), .DEPTH(8), .LEN_W(4), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
`ifdef NOC_DP_PKT_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif
    int checks = 0;
    int failures = 0;
    int pkts = 0;
    logic [31:0] exp_q [$];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic chk_cnt();
        chk("pkt_count", 32'(bus.pkt_count), CNT_ON ? 32'(pkts) : 32'd0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic gp, input logic te, input logic [31:0] f, input logic acc);
        bus.get_packet  = gp;
        bus.transfer_en = te;
        bus.src_flit    = f;
        bus.dest_accept = acc;
    endtask

    task automatic send(input logic [31:0] f, input logic acc);
        drv(1'b1, 1'b1, f, acc);
        exp_q.push_back(f);
        cyc();
    endtask

    task automatic drain();
        drv(1'b0, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) cyc();
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d flits outstanding expected 0", exp_q.size());
        end
        cyc();
        chk("drained_valid", 32'(bus.dest_valid), 32'd0);
    endtask

    always @(negedge clk) begin
        if (bus.dest_valid && bus.dest_accept) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_flit: got %h expected none", bus.dest_flit);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("dest_flit", bus.dest_flit, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        drv(1'b0, 1'b0, 32'd0, 1'b0);
        #12;
        chk("rst_stop", 32'(bus.stop), 32'd0);
        chk("rst_hold", 32'(bus.src_hold), 32'd0);
        chk("rst_valid", 32'(bus.dest_valid), 32'd0);
        chk("rst_flit", bus.dest_flit, 32'd0);
        chk_cnt();
        @(negedge clk) reset = 1'b0;
        cyc();
        // Packet of length 2, streamed straight through
        drv(1'b1, 1'b0, 32'h7777_0003, 1'b1);
        cyc();
        chk("te_gate", 32'(bus.dest_valid), 32'd0);
        send(32'hA000_0002, 1'b1);
        chk("s1_stop_hdr", 32'(bus.stop), 32'd0);
        send(32'hA111_1111, 1'b1);
        chk("s1_stop_b1", 32'(bus.stop), 32'd0);
        send(32'hA222_2222, 1'b1);
        chk("s1_stop", 32'(bus.stop), 32'd1);
        pkts++;
        drv(1'b1, 1'b1, 32'hBAD0_0001, 1'b1);
        cyc();
        chk("s1_stop_once", 32'(bus.stop), 32'd0);
        chk_cnt();
        drv(1'b0, 1'b0, 32'd0, 1'b1);
        cyc();
        chk("s1_empty", 32'(bus.dest_valid), 32'd0);
        // Zero-length packet
        send(32'h1234_5670, 1'b0);
        chk("s2_stop", 32'(bus.stop), 32'd1);
        pkts++;
        drv(1'b0, 1'b0, 32'd0, 1'b0);
        cyc();
        chk("s2_stop_once", 32'(bus.stop), 32'd0);
        chk_cnt();
        chk("s2_valid", 32'(bus.dest_valid), 32'd1);
        chk("s2_flit", bus.dest_flit, 32'h1234_5670);
        drv(1'b0, 1'b0, 32'd0, 1'b1);
        cyc();
        chk("s2_one_flit", 32'(bus.dest_valid), 32'd0);
        // Backpressure: fill to DEPTH with a length-10 packet
        send(32'hC000_000A, 1'b0);
        for (int i = 1; i <= 7; i++) send(32'hC100_0000 + 32'(i), 1'b0);
        chk("s3_full", 32'(bus.src_hold), 32'd1);
        chk("s3_nostop", 32'(bus.stop), 32'd0);
        drv(1'b1, 1'b1, 32'hC100_0008, 1'b0);
        cyc();
        chk("s3_hold", 32'(bus.src_hold), 32'd1);
        chk("s3_stable", bus.dest_flit, 32'hC000_000A);
        drv(1'b1, 1'b1, 32'hC100_0008, 1'b1);
        cyc();
        chk("s3_popped", 32'(bus.src_hold), 32'd0);
        send(32'hC100_0008, 1'b0);
        chk("s3_refull", 32'(bus.src_hold), 32'd1);
        drv(1'b0, 1'b0, 32'd0, 1'b1);
        cyc();
        send(32'hC100_0009, 1'b1);
        chk("s3_stop_b9", 32'(bus.stop), 32'd0);
        chk("s3_hold_b9", 32'(bus.src_hold), 32'd0);
        send(32'hC100_000A, 1'b1);
        chk("s3_stop", 32'(bus.stop), 32'd1);
        pkts++;
        drain();
        chk_cnt();
        // Simultaneous push/pop at occupancy 4, length-15 packet
        send(32'hD000_000F, 1'b0);
        for (int i = 1; i <= 3; i++) send(32'hD100_0000 + 32'(i), 1'b0);
        send(32'hD100_0004, 1'b1);
        send(32'hD100_0005, 1'b1);
        for (int i = 6; i <= 8; i++) send(32'hD100_0000 + 32'(i), 1'b0);
        chk("s4_occ7", 32'(bus.src_hold), 32'd0);
        send(32'hD100_0009, 1'b0);
        chk("s4_occ8", 32'(bus.src_hold), 32'd1);
        drv(1'b0, 1'b0, 32'd0, 1'b1);
        cyc();
        for (int i = 10; i <= 14; i++) send(32'hD100_0000 + 32'(i), 1'b1);
        chk("s4_stop_pre", 32'(bus.stop), 32'd0);
        send(32'hD100_000F, 1'b1);
        chk("s4_stop", 32'(bus.stop), 32'd1);
        pkts++;
        drain();
        chk_cnt();
        // Reset mid-body with remaining = 3 and two flits buffered
        send(32'hE000_0004, 1'b0);
        send(32'hE100_0001, 1'b0);
        chk("s5_buffered", 32'(bus.dest_valid), 32'd1);
        drv(1'b0, 1'b0, 32'd0, 1'b0);
        #2 reset = 1'b1;
        #1;
        exp_q.delete();
        pkts = 0;
        chk("s5_rst_stop", 32'(bus.stop), 32'd0);
        chk("s5_rst_hold", 32'(bus.src_hold), 32'd0);
        chk("s5_rst_valid", 32'(bus.dest_valid), 32'd0);
        chk("s5_rst_flit", bus.dest_flit, 32'd0);
        chk_cnt();
        @(negedge clk) reset = 1'b0;
        cyc();
        send(32'hF000_0001, 1'b1);
        chk("s5_stop_hdr", 32'(bus.stop), 32'd0);
        send(32'h5555_5555, 1'b1);
        chk("s5_stop", 32'(bus.stop), 32'd1);
        pkts++;
        drain();
        chk_cnt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
